// File: rtl/snes_pkg.sv
// Shared constants, FSM encoding and event payload for the SNES button event front-end.
package snes_pkg;

  localparam int unsigned BTN_W       = 12;
  localparam int unsigned BTN_IDX_W   = 4;
  localparam int unsigned EVT_W       = 8;
  localparam int unsigned EVT_REL_BIT = 7;

  localparam int unsigned BTN_B     = 11;
  localparam int unsigned BTN_Y     = 10;
  localparam int unsigned BTN_SEL   = 9;
  localparam int unsigned BTN_START = 8;
  localparam int unsigned BTN_UP    = 7;
  localparam int unsigned BTN_DN    = 6;
  localparam int unsigned BTN_L     = 5;
  localparam int unsigned BTN_R     = 4;
  localparam int unsigned BTN_A     = 3;
  localparam int unsigned BTN_X     = 2;
  localparam int unsigned BTN_LB    = 1;
  localparam int unsigned BTN_RB    = 0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    EVAL = 3'd3,
    SCAN = 3'd4
  } state_e;

  // Event byte: bit EVT_REL_BIT is the release flag, low nibble the button index.
  typedef struct packed {
    logic                 rel;
    logic [2:0]           rsvd;
    logic [BTN_IDX_W-1:0] idx;
  } evt_t;

  // Index of the most significant set bit; 0 when no bit is set.
  function automatic logic [BTN_IDX_W-1:0] highest_set(input logic [BTN_W-1:0] v);
    highest_set = '0;
    for (int i = 0; i < BTN_W; i++) begin
      if (v[i]) highest_set = BTN_IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/snes_evt_fifo.sv
// Synchronous event FIFO with registered head/valid; pop frees a slot for a same-cycle push.
module snes_evt_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_valid,
  output logic             o_full_c,
  output logic             o_empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_head;
  logic             r_valid;

  logic             w_pop;
  logic             w_push;
  logic [PTR_W-1:0] w_rd_nxt;
  logic [CNT_W-1:0] w_rem;
  logic [CNT_W-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign o_full_c  = (r_count == CNT_W'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_head    = r_head;
  assign o_valid   = r_valid;

  assign w_pop       = i_pop & ~o_empty_c;
  assign w_push      = i_push & (~o_full_c | w_pop);
  assign w_rd_nxt    = r_rd_ptr + PTR_W'(w_pop);
  assign w_rem       = r_count - CNT_W'(w_pop);
  assign w_count_nxt = w_rem + CNT_W'(w_push);

  // Head bypass: when nothing older remains, the pushed word becomes the head directly.
  always_comb begin
    w_head_nxt = r_mem[w_rd_nxt];
    if (w_rem == '0) w_head_nxt = i_push_data;
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
      r_head   <= w_head_nxt;
      r_valid  <= (w_count_nxt != '0);
    end
  end

endmodule

// File: rtl/snes_button_events.sv
// Polls the SNES pad, debounces the button word and queues one event per press.
// Define SNES_RELEASE_EVT_EN to also queue release events (evt_data[7]=1).
module snes_button_events
  import snes_pkg::*;
#(
  parameter int unsigned POLL_DIV   = 266667,
  parameter int unsigned STABLE_CNT = 2,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic             sys_clk,
  input  logic             sys_reset_n,
  output logic             read_enable,
  input  logic             read_complete,
  input  logic [BTN_W-1:0] snes_buttons,
  output logic [BTN_W-1:0] buttons_stable,
  output logic             evt_valid,
  output logic [EVT_W-1:0] evt_data,
  input  logic             evt_ready,
  output logic             overflow,
  output logic             timeout_err
);

  localparam int unsigned POLL_W  = $clog2(POLL_DIV);
  localparam int unsigned WAIT_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned MATCH_W = $clog2(STABLE_CNT + 1);

  state_e               r_state;
  logic [POLL_W-1:0]    r_poll_cnt;
  logic                 r_poll_pend;
  logic [WAIT_W-1:0]    r_wait_cnt;
  logic [BTN_W-1:0]     r_raw;
  logic [BTN_W-1:0]     r_last_raw;
  logic [MATCH_W-1:0]   r_match_cnt;
  logic [BTN_W-1:0]     r_stable;
  logic [BTN_W-1:0]     r_pending;
  logic                 r_read_enable;
  logic                 r_overflow;
  logic                 r_timeout_err;

  state_e               w_state_nxt;
  logic                 w_tick;
  logic                 w_poll_pend_nxt;
  logic [WAIT_W-1:0]    w_wait_cnt_nxt;
  logic [BTN_W-1:0]     w_raw_nxt;
  logic [BTN_W-1:0]     w_last_raw_nxt;
  logic [MATCH_W-1:0]   w_match_nxt;
  logic [BTN_W-1:0]     w_stable_nxt;
  logic [BTN_W-1:0]     w_pending_nxt;
  logic [BTN_W-1:0]     w_diff;
  logic                 w_timeout_nxt;
  logic [BTN_IDX_W-1:0] w_idx;
  logic                 w_push;
  evt_t                 w_evt;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_drop;

  assign w_tick = (r_poll_cnt == POLL_W'(POLL_DIV - 1));
  assign w_idx  = highest_set(r_pending);
  // SCAN never stalls: a push into a full FIFO without a same-cycle pop is lost.
  assign w_drop = w_push & w_full & ~(evt_ready & ~w_empty);

  assign read_enable    = r_read_enable;
  assign buttons_stable = r_stable;
  assign overflow       = r_overflow;
  assign timeout_err    = r_timeout_err;

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) r_state <= IDLE;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_poll_pend_nxt = r_poll_pend;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_raw_nxt       = r_raw;
    w_last_raw_nxt  = r_last_raw;
    w_match_nxt     = r_match_cnt;
    w_stable_nxt    = r_stable;
    w_pending_nxt   = r_pending;
    w_diff          = '0;
    w_timeout_nxt   = r_timeout_err;
    w_push          = 1'b0;
    w_evt           = '0;
    unique case (r_state)
      IDLE: begin
        if (w_tick | r_poll_pend) begin
          w_state_nxt     = REQ;
          w_poll_pend_nxt = 1'b0;
        end
      end
      REQ: begin
        w_state_nxt    = WAIT;
        w_wait_cnt_nxt = '0;
      end
      WAIT: begin
        if (read_complete) begin
          w_raw_nxt   = snes_buttons;
          w_state_nxt = EVAL;
        end else if (r_wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = IDLE;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
      EVAL: begin
        if (r_raw != r_last_raw)                       w_match_nxt = MATCH_W'(1);
        else if (r_match_cnt != MATCH_W'(STABLE_CNT))  w_match_nxt = r_match_cnt + MATCH_W'(1);
        w_last_raw_nxt = r_raw;
        w_state_nxt    = IDLE;
        if ((w_match_nxt == MATCH_W'(STABLE_CNT)) && (r_raw != r_stable)) begin
`ifdef SNES_RELEASE_EVT_EN
          w_diff = r_raw ^ r_stable;
`else
          w_diff = (r_raw ^ r_stable) & r_raw;
`endif
          w_stable_nxt  = r_raw;
          w_pending_nxt = w_diff;
          if (w_diff != '0) w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        w_push    = 1'b1;
        w_evt.idx = w_idx;
`ifdef SNES_RELEASE_EVT_EN
        w_evt.rel = ~r_stable[w_idx];
`endif
        w_pending_nxt = r_pending & ~(BTN_W'(1) << w_idx);
        if (w_pending_nxt == '0) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // A tick that arrives while a poll is in flight is remembered once.
    if (w_tick && (r_state != IDLE)) w_poll_pend_nxt = 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      r_poll_cnt    <= '0;
      r_poll_pend   <= 1'b0;
      r_wait_cnt    <= '0;
      r_raw         <= '0;
      r_last_raw    <= '0;
      r_match_cnt   <= '0;
      r_stable      <= '0;
      r_pending     <= '0;
      r_read_enable <= 1'b0;
      r_overflow    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_poll_cnt    <= w_tick ? '0 : r_poll_cnt + POLL_W'(1);
      r_poll_pend   <= w_poll_pend_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_raw         <= w_raw_nxt;
      r_last_raw    <= w_last_raw_nxt;
      r_match_cnt   <= w_match_nxt;
      r_stable      <= w_stable_nxt;
      r_pending     <= w_pending_nxt;
      r_read_enable <= (w_state_nxt == REQ);
      r_overflow    <= r_overflow | w_drop;
      r_timeout_err <= w_timeout_nxt;
    end
  end

  snes_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .i_clk       (sys_clk),
    .i_rst_n     (sys_reset_n),
    .i_push      (w_push),
    .i_push_data (w_evt),
    .i_pop       (evt_ready),
    .o_head      (evt_data),
    .o_valid     (evt_valid),
    .o_full_c    (w_full),
    .o_empty_c   (w_empty)
  );

endmodule

// File: tb/tb_snes_button_events.sv
// Scoreboard bench for snes_button_events with a 52-cycle SnesInterface model.
// Honours SNES_RELEASE_EVT_EN for the expected release events.
module tb_snes_button_events;

  logic        sys_clk = 1'b0;
  logic        sys_reset_n = 1'b0;
  logic        read_enable;
  logic        read_complete = 1'b0;
  logic [11:0] snes_buttons = '0;
  logic [11:0] buttons_stable;
  logic        evt_valid;
  logic [7:0]  evt_data;
  logic        evt_ready = 1'b1;
  logic        overflow;
  logic        timeout_err;

  logic [11:0] pad = '0;
  bit          withhold = 1'b0;
  logic [7:0]  exp_q[$];
  logic [7:0]  sb_exp;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n;
  int          run;

  snes_button_events #(
    .POLL_DIV   (100),
    .STABLE_CNT (2),
    .FIFO_DEPTH (4),
    .TIMEOUT    (63)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_reset_n    (sys_reset_n),
    .read_enable    (read_enable),
    .read_complete  (read_complete),
    .snes_buttons   (snes_buttons),
    .buttons_stable (buttons_stable),
    .evt_valid      (evt_valid),
    .evt_data       (evt_data),
    .evt_ready      (evt_ready),
    .overflow       (overflow),
    .timeout_err    (timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  // SnesInterface model: read_complete 52 cycles after read_enable, driven on negedges.
  initial begin
    forever begin
      @(posedge sys_clk);
      #1;
      if (read_enable && !withhold) begin
        repeat (51) @(posedge sys_clk);
        @(negedge sys_clk);
        read_complete = 1'b1;
        snes_buttons  = pad;
        @(negedge sys_clk);
        read_complete = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_rc(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge sys_clk);
      #1;
      if (read_complete) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: read_complete not seen within 400 cycles", name);
    end
  endtask

  task automatic wait_re(input string name, output int cycles);
    bit seen = 1'b0;
    cycles = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge sys_clk);
      #1;
      cycles++;
      if (read_enable) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: read_enable not seen within 400 cycles", name);
    end
  endtask

  task automatic do_poll(input string name);
    wait_rc(name);
    repeat (10) @(posedge sys_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read_enable"}, int'(read_enable), 0);
    chk({tag, "_evt_valid"}, int'(evt_valid), 0);
    chk({tag, "_evt_data"}, int'(evt_data), 0);
    chk({tag, "_stable"}, int'(buttons_stable), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
    chk({tag, "_timeout_err"}, int'(timeout_err), 0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge sys_clk);
        if (sys_reset_n && evt_valid && evt_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL evt_unexpected: got 0x%02h, expected no event", evt_data);
          end else begin
            sb_exp = exp_q.pop_front();
            chk("evt_data", int'(evt_data), int'(sb_exp));
          end
        end
      end
    join_none

    // Reset state and first poll request
    repeat (3) @(posedge sys_clk);
    #1;
    chk_all_zero("rst");
    sys_reset_n = 1'b1;
    wait_re("first_req", n);
    chk("first_req_cycles", n, 100);
    wait_rc("poll0");

    // One-poll glitch on X is filtered
    pad = 12'h004;
    do_poll("glitch_1");
    pad = 12'h000;
    do_poll("glitch_2");
    do_poll("glitch_3");
    chk("glitch_stable", int'(buttons_stable), 12'h000);

    // Press A for two polls
    pad = 12'h008;
    do_poll("a_1");
    chk("a_stable_after_1", int'(buttons_stable), 12'h000);
    exp_q.push_back(8'h03);
    do_poll("a_2");
    chk("a_stable_after_2", int'(buttons_stable), 12'h008);

    // Release A
    pad = 12'h000;
    do_poll("rel_a_1");
`ifdef SNES_RELEASE_EVT_EN
    exp_q.push_back(8'h83);
`endif
    do_poll("rel_a_2");
    chk("rel_a_stable", int'(buttons_stable), 12'h000);

    // B+Start+RB together: three events on consecutive cycles
    pad = 12'h901;
    do_poll("multi_1");
    exp_q.push_back(8'h0B);
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h00);
    wait_rc("multi_2");
    for (int i = 0; i < 20 && !evt_valid; i++) begin
      @(posedge sys_clk);
      #1;
    end
    run = 0;
    while (evt_valid && run < 10) begin
      run++;
      @(posedge sys_clk);
      #1;
    end
    chk("multi_run_len", run, 3);
    chk("multi_stable", int'(buttons_stable), 12'h901);

    // Release everything
    pad = 12'h000;
    do_poll("rel_all_1");
`ifdef SNES_RELEASE_EVT_EN
    exp_q.push_back(8'h8B);
    exp_q.push_back(8'h88);
    exp_q.push_back(8'h80);
`endif
    do_poll("rel_all_2");
    chk("rel_all_stable", int'(buttons_stable), 12'h000);
    chk("ovf_before", int'(overflow), 0);

    // Six presses into a 4-deep FIFO with consumer stalled
    evt_ready = 1'b0;
    pad = 12'h0FC;
    do_poll("ovf_1");
    exp_q.push_back(8'h07);
    exp_q.push_back(8'h06);
    exp_q.push_back(8'h05);
    exp_q.push_back(8'h04);
    do_poll("ovf_2");
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_valid", int'(evt_valid), 1);
    chk("ovf_head", int'(evt_data), 8'h07);
    chk("ovf_stable", int'(buttons_stable), 12'h0FC);

    // Push onto full FIFO in the same cycle as a pop: no drop
    pad = 12'h8FC;
    do_poll("pp_1");
    exp_q.push_back(8'h0B);
    wait_rc("pp_2");
    @(posedge sys_clk);
    #1;
    evt_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    evt_ready = 1'b0;
    repeat (10) @(posedge sys_clk);
    #1;
    chk("pp_stable", int'(buttons_stable), 12'h8FC);
    chk("pp_still_full_head", int'(evt_data), 8'h06);
    evt_ready = 1'b1;
    repeat (10) @(posedge sys_clk);
    #1;
    chk("pp_drained", exp_q.size(), 0);
    chk("pp_empty", int'(evt_valid), 0);

    // read_complete withheld -> timeout, then normal polling resumes
    withhold = 1'b1;
    wait_re("to_req", n);
    n = 0;
    for (int i = 0; i < 100 && !timeout_err; i++) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    chk_range("timeout_latency", n, 63, 65);
    chk("timeout_flag", int'(timeout_err), 1);
    withhold = 1'b0;
    do_poll("after_timeout");
    chk("after_timeout_stable", int'(buttons_stable), 12'h8FC);
    chk("timeout_sticky", int'(timeout_err), 1);

    // Reset in the first SCAN cycle with three presses pending
    pad = 12'hFFC;
    do_poll("rst_scan_1");
    wait_rc("rst_scan_2");
    @(posedge sys_clk);
    #1;
    sys_reset_n = 1'b0;
    @(posedge sys_clk);
    #1;
    chk_all_zero("rst_scan");
    sys_reset_n = 1'b1;
    wait_re("rst_scan_req", n);
    chk("rst_scan_req_cycles", n, 100);
    repeat (20) @(posedge sys_clk);
    #1;
    chk("sb_final_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
